// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types for the APB master arbiter.
// Holds the FSM state encoding and the wait counter width.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// apb_arb_rr: combinational round-robin selector.
// The search starts one past the last grant and wraps.
module apb_arb_rr
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand [NUM_REQ];
    logic             w_found;

    // Candidate order: last+1, last+2, ... modulo NUM_REQ
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_cand[i] = IDX_W'((int'(i_last) + i + 1) % int'(NUM_REQ));
        end
    end

    // First requesting candidate wins
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!w_found && i_req[w_cand[i]]) begin
                w_found          = 1'b1;
                o_gnt[w_cand[i]] = 1'b1;
                o_idx            = w_cand[i];
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: N requesters sharing one APB master port.
// Round-robin grant, registered APB outputs, access timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned           APB_ADDR_WIDTH = 32,
    parameter int unsigned           APB_DATA_WIDTH = 32,
    parameter int unsigned           NUM_REQ        = 2,
    parameter logic [WAIT_CNT_W-1:0] TIMEOUT_CYCLES = 16'd256
) (
    input  logic                              apb_pclk_i,
    input  logic                              apb_preset_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]                req_write_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                              rsp_err_o,
    output logic                              apb_psel_o,
    output logic                              apb_penable_o,
    output logic                              apb_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]         apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]         apb_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]         apb_prdata_i,
    input  logic                              apb_pready_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    logic [IDX_W-1:0]          r_last_grant;
    logic [NUM_REQ-1:0]        r_gnt_oh;
    logic [WAIT_CNT_W-1:0]     r_wait_cnt;

    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;

    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                      r_rsp_err;

    logic [NUM_REQ-1:0]        w_gnt_oh;
    logic [IDX_W-1:0]          w_gnt_idx;
    logic                      w_any;
    logic                      w_accept;
    logic                      w_done;
    logic                      w_timeout;
    logic [NUM_REQ-1:0]        w_req_ready;
    logic                      w_psel_nxt;
    logic                      w_penable_nxt;

    logic [APB_ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [APB_DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign w_addr_arr[k]  = req_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign w_wdata_arr[k] = req_wdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    apb_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req  (req_valid_i),
        .i_last (r_last_grant),
        .o_gnt  (w_gnt_oh),
        .o_idx  (w_gnt_idx),
        .o_any  (w_any)
    );

    assign w_accept  = (r_state == ST_IDLE) && w_any;
    assign w_done    = (r_state == ST_ACCESS) && apb_pready_i;
    // A pready in the threshold cycle wins over the timeout
    assign w_timeout = (r_state == ST_ACCESS) && !apb_pready_i
                    && (TIMEOUT_CYCLES != '0)
                    && (r_wait_cnt == TIMEOUT_CYCLES - 1'b1);

    // State register
    always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
        if (!apb_preset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_any) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done || w_timeout) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant strobe and next APB control levels
    always_comb begin
        w_req_ready   = '0;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        if (r_state == ST_IDLE && apb_preset_ni) begin
            w_req_ready = w_gnt_oh;
        end
        unique case (w_state_nxt)
            ST_SETUP: w_psel_nxt = 1'b1;
            ST_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered APB control so psel/penable come straight from flops
    always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
        if (!apb_preset_ni) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
        end
    end

    // Payload and grant capture; only touched on acceptance
    always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
        if (!apb_preset_ni) begin
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
            r_gnt_oh     <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_paddr      <= w_addr_arr[w_gnt_idx];
            r_pwrite     <= req_write_i[w_gnt_idx];
            r_pwdata     <= w_wdata_arr[w_gnt_idx];
            r_gnt_oh     <= w_gnt_oh;
            r_last_grant <= w_gnt_idx;
        end
    end

    // Access wait counter: cleared in SETUP, counts stalled ACCESS cycles
    always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
        if (!apb_preset_ni) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ACCESS && !apb_pready_i) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Completion pulse with read data or timeout error
    always_ff @(posedge apb_pclk_i or negedge apb_preset_ni) begin
        if (!apb_preset_ni) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_done) begin
                r_rsp_valid <= r_gnt_oh;
                r_rsp_rdata <= r_pwrite ? '0 : apb_prdata_i;
                r_rsp_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid <= r_gnt_oh;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign req_ready_o   = w_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign apb_psel_o    = r_psel;
    assign apb_penable_o = r_penable;
    assign apb_pwrite_o  = r_pwrite;
    assign apb_paddr_o   = r_paddr;
    assign apb_pwdata_o  = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-age model.
module tb_apb_master_arbiter;

    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam int          NR = 3;
    localparam logic [15:0] TO = 16'd8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    logic [AW-1:0] b_addr  [NR];
    logic [DW-1:0] b_wdata [NR];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            req_addr[k*AW +: AW]  = b_addr[k];
            req_wdata[k*DW +: DW] = b_wdata[k];
        end
    end

    apb_master_arbiter #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .apb_pclk_i    (clk),
        .apb_preset_ni (rst_n),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .req_ready_o   (req_ready),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .apb_psel_o    (psel),
        .apb_penable_o (penable),
        .apb_pwrite_o  (pwrite),
        .apb_paddr_o   (paddr),
        .apb_pwdata_o  (pwdata),
        .apb_prdata_i  (prdata),
        .apb_pready_i  (pready)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // A transfer is tracked by its age in cycles since acceptance:
    // age 1 is the setup cycle, age >= 2 are access cycles.
    logic          m_busy;
    int            m_age;
    int            m_g;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [DW-1:0] m_wd;
    int            m_last;
    logic          m_rsp;
    int            m_rsp_g;
    logic          m_rsp_err;
    logic [DW-1:0] m_rsp_data;
    logic [NR-1:0] m_acc;
    int            m_acc_cnt = 0;
    int            m_abort = 0;
    int            dut_rsp_cnt = 0;

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int i = 1; i <= NR; i++) begin
            if (v[(last + i) % NR]) return (last + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic model_reset();
        if (m_busy === 1'b1 || m_rsp === 1'b1) m_abort++;
        m_busy = 0;
        m_age  = 0;
        m_g    = 0;
        m_last = NR - 1;
        m_rsp  = 0;
        m_acc  = '0;
    endtask

    task automatic model_finish(input logic [DW-1:0] d, input logic e);
        m_rsp      = 1;
        m_rsp_g    = m_g;
        m_rsp_data = d;
        m_rsp_err  = e;
        m_busy     = 0;
    endtask

    // Compare process: outputs checked at every falling edge
    always @(negedge clk) begin
        int            g;
        logic [NR-1:0] e_rdy;
        if (!rst_n) begin
            model_reset();
            chk("reset_ctrl", {psel, penable, pwrite, rsp_err,
                               rsp_valid, req_ready}, 0);
            chk("reset_paddr", paddr, 0);
            chk("reset_pwdata", pwdata, 0);
            chk("reset_rdata", rsp_rdata, 0);
        end else begin
            g     = m_busy ? -1 : rr_pick(req_valid, m_last);
            e_rdy = (g >= 0) ? oh(g) : '0;
            chk("req_ready", req_ready, e_rdy);
            chk("ready_onehot0", $onehot0(req_ready), 1);
            chk("psel", psel, m_busy);
            chk("penable", penable, m_busy && m_age >= 2);
            chk("penable_implies_psel", !penable || psel, 1);
            if (m_busy) begin
                chk("paddr", paddr, m_addr);
                chk("pwrite", pwrite, m_wr);
                chk("pwdata", pwdata, m_wd);
            end
            chk("rsp_valid", rsp_valid, m_rsp ? oh(m_rsp_g) : '0);
            if (m_rsp) begin
                chk("rsp_rdata", rsp_rdata, m_rsp_data);
                chk("rsp_err", rsp_err, m_rsp_err);
            end
            dut_rsp_cnt += $countones(rsp_valid);
            m_rsp = 0;
            m_acc = '0;
            if (m_busy) begin
                if (m_age == 1) m_age = 2;
                else if (pready) model_finish(m_wr ? '0 : prdata, 0);
                else if (TO != 0 && m_age - 2 == int'(TO) - 1)
                    model_finish('0, 1);
                else m_age++;
            end else if (g >= 0) begin
                m_g    = g;
                m_addr = b_addr[g];
                m_wr   = req_write[g];
                m_wd   = b_wdata[g];
                m_last = g;
                m_busy = 1;
                m_age  = 1;
                m_acc  = oh(g);
                m_acc_cnt++;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input int k, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
        int ok;
        @(posedge clk); #1;
        b_addr[k]    = a;
        req_write[k] = w;
        b_wdata[k]   = d;
        req_valid[k] = 1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (req_ready[k]) ok = 1;
        end
        @(posedge clk); #1;
        req_valid[k] = 0;
        chk("grant_wait", ok, 1);
    endtask

    task automatic observe(input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d, input int rdy_after,
                           output int n_sel, output int n_en,
                           output logic [NR-1:0] rv,
                           output logic [DW-1:0] rd,
                           output logic er, output int bad);
        n_sel = 0; n_en = 0; rv = '0; rd = '0; er = 0; bad = 0;
        for (int i = 0; i < 40 && rv == '0; i++) begin
            @(negedge clk);
            if (psel) begin
                n_sel++;
                if (paddr !== a || pwdata !== d || pwrite !== w) bad++;
            end
            if (penable) n_en++;
            if (rsp_valid != '0) begin
                rv = rsp_valid;
                rd = rsp_rdata;
                er = rsp_err;
            end
            if (rdy_after >= 0 && n_en == rdy_after && !pready) begin
                @(posedge clk); #1;
                pready = 1;
            end
        end
    endtask

    task automatic new_req(input int k);
        b_addr[k]    = $urandom();
        b_wdata[k]   = $urandom();
        req_write[k] = 1'($urandom_range(1));
        req_valid[k] = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            ns, ne, bad, cyc;
        logic [NR-1:0] rv, first;
        logic [DW-1:0] rd;
        logic          er, dropped;
        int            order[$];
        int            setup_at[$];
        int            exp_order [6] = '{0, 1, 0, 1, 0, 1};
        int            p_rdy;

        req_valid = '0;
        req_write = '0;
        pready    = 0;
        prdata    = '0;
        for (int k = 0; k < NR; k++) begin
            b_addr[k]  = '0;
            b_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // Two requesters always valid: strict alternation, 3-cycle cadence
        @(posedge clk); #1;
        pready = 1;
        prdata = 32'h0000_1111;
        b_addr[0] = 32'h100; b_addr[1] = 32'h200;
        req_valid = 3'b011;
        cyc = 0; dropped = 0;
        while (setup_at.size() < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) order.push_back($clog2(req_ready));
            if (psel && !penable) setup_at.push_back(cyc);
            if (order.size() == 6 && !dropped) begin
                @(posedge clk); #1;
                req_valid = '0;
                dropped = 1;
            end
        end
        chk("grant_count", order.size(), 6);
        chk("setup_count", setup_at.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("grant_order", order[i], exp_order[i]);
        for (int i = 1; i < setup_at.size(); i++)
            chk("setup_spacing", setup_at[i] - setup_at[i-1], 3);
        repeat (3) @(posedge clk);

        // Zero-wait read
        pready = 1;
        prdata = 32'hDEAD_BEEF;
        issue(0, 32'h1000, 0, 32'h0);
        observe(32'h1000, 0, 32'h0, -1, ns, ne, rv, rd, er, bad);
        chk("rd_psel_cycles", ns, 2);
        chk("rd_penable_cycles", ne, 1);
        chk("rd_rsp_valid", rv, 3'b001);
        chk("rd_rdata", rd, 32'hDEAD_BEEF);
        chk("rd_err", er, 0);

        // Write with 5 wait states
        pready = 0;
        prdata = 32'h1234_5678;
        issue(1, 32'h20, 1, 32'hA5A5_A5A5);
        observe(32'h20, 1, 32'hA5A5_A5A5, 5, ns, ne, rv, rd, er, bad);
        chk("wr_access_cycles", ne, 6);
        chk("wr_psel_cycles", ns, 7);
        chk("wr_payload_stable", bad, 0);
        chk("wr_rsp_valid", rv, 3'b010);
        chk("wr_rdata_zero", rd, 0);
        chk("wr_err", er, 0);

        // Timeout with pready never asserted
        pready = 0;
        prdata = 32'hFFFF_FFFF;
        issue(2, 32'h3000, 0, 32'h0);
        observe(32'h3000, 0, 32'h0, -1, ns, ne, rv, rd, er, bad);
        chk("to_access_cycles", ne, int'(TO));
        chk("to_rsp_valid", rv, 3'b100);
        chk("to_err", er, 1);
        chk("to_rdata", rd, 0);
        pready = 1;
        prdata = 32'h0BAD_CAFE;
        issue(0, 32'h44, 0, 32'h0);
        observe(32'h44, 0, 32'h0, -1, ns, ne, rv, rd, er, bad);
        chk("after_to_rsp", rv, 3'b001);
        chk("after_to_rdata", rd, 32'h0BAD_CAFE);

        // Reset in the second access cycle
        pready = 0;
        issue(0, 32'h50, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_penable", penable, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_ctrl", {psel, penable, pwrite, rsp_err,
                               rsp_valid, req_ready}, 0);
        chk("async_rst_paddr", paddr, 0);
        b_addr[1] = 32'h77;
        req_write[1] = 0;
        req_valid[1] = 1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        pready = 1;
        prdata = 32'h5555_AAAA;
        first = '0;
        for (int i = 0; i < 10 && first == '0; i++) begin
            @(negedge clk);
            first = req_ready;
            chk("no_rsp_after_reset", rsp_valid, 0);
        end
        chk("first_grant_after_reset", first, 3'b010);
        @(posedge clk); #1;
        req_valid[1] = 0;
        observe(32'h77, 0, b_wdata[1], -1, ns, ne, rv, rd, er, bad);
        chk("post_reset_rsp", rv, 3'b010);

        // Random traffic
        for (int i = 0; i < 4500; i++) begin
            p_rdy = (i < 1500) ? 85 : (i < 3000) ? 40 : 8;
            @(posedge clk); #1;
            if (i == 1200 || i == 3700) begin
                rst_n = 0;
                @(posedge clk);
                @(posedge clk);
                #2 rst_n = 1;
            end
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && m_acc[k]) begin
                    if ($urandom_range(1) == 1) new_req(k);
                    else req_valid[k] = 0;
                end else if (req_valid[k]) begin
                    if ($urandom_range(15) == 0) req_valid[k] = 0;
                end else if ($urandom_range(2) == 0) begin
                    new_req(k);
                end
            end
            pready = ($urandom_range(99) < p_rdy);
            prdata = $urandom();
        end

        @(posedge clk); #1;
        req_valid = '0;
        pready    = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("one_rsp_per_accept", dut_rsp_cnt,
            m_acc_cnt - m_abort - ((m_busy || m_rsp) ? 1 : 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
